// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings, fetch FSM states and PC defaults.
// Consumers may define FETCH_ALIGN_CHECK_EN to enable the misaligned-PC trap in fetch_unit.
package cpu_pkg;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_JR  = 2'b01;
    localparam logic [1:0] PCS_BR  = 2'b10;
    localparam logic [1:0] PCS_J   = 2'b11;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC_DEFAULT  = 32'h0000_0080;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, jr, PC-relative branch or pseudo-direct jump.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic [31:0] jr_target,
    input  logic [1:0]  PC_s,
    output logic [31:0] next_pc
);

    logic [31:0] br_offset;

    assign br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

    // Any select that is not an exact control encoding (including x from a
    // non-control instruction) falls through to the sequential path.
    always_comb begin
        next_pc = pc_plus4;
        case (PC_s)
            PCS_JR:  next_pc = jr_target;
            PCS_BR:  next_pc = pc_plus4 + br_offset;
            PCS_J:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch / PC stage: two-state FETCH/EXEC FSM over a stallable instruction memory.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned next-PC values to TRAP_PC and raise misalign_err.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
`ifdef FETCH_ALIGN_CHECK_EN
   ,parameter logic [31:0] TRAP_PC  = TRAP_PC_DEFAULT
`endif
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    input  logic [1:0]  PC_s,
    input  logic [31:0] jr_target,
    input  logic        retire,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
`ifdef FETCH_ALIGN_CHECK_EN
   ,output logic        misalign_err
`endif
);

    fetch_state_t state;
    logic [31:0]  next_pc_raw;
    logic [31:0]  next_pc;

    assign pc_plus4  = pc + 32'd4;
    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];
    assign imem_addr = pc;

    next_pc_calc u_next_pc_calc (
        .pc_plus4  (pc_plus4),
        .instr     (instr),
        .jr_target (jr_target),
        .PC_s      (PC_s),
        .next_pc   (next_pc_raw)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = |next_pc_raw[1:0];
    assign next_pc    = misaligned ? TRAP_PC : next_pc_raw;
`else
    assign next_pc    = next_pc_raw & ~32'h0000_0003;
`endif

    // imem_req is low during reset and the first cycle after it, so a response
    // to a fetch cut off by reset can never be mistaken for the re-issued one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            instr        <= 32'h0000_0000;
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (imem_req && imem_valid) begin
                        instr       <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= EXEC;
                    end else begin
                        imem_req    <= 1'b1;
                    end
                end
                EXEC: begin
                    if (retire) begin
                        pc          <= next_pc;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
                        if (misaligned)
                            misalign_err <= 1'b1;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a per-cycle reference model plus directed literal checks.
// Honours FETCH_ALIGN_CHECK_EN to expect trap behaviour on a misaligned jr target.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [31:0] TRAP_PC  = 32'h0000_0080;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_valid = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [1:0]  PC_s = 2'b00;
    logic [31:0] jr_target = 32'h0;
    logic        retire = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int tests = 0;
    int fails = 0;

    fetch_unit #(
        .RESET_PC (RESET_PC)
`ifdef FETCH_ALIGN_CHECK_EN
       ,.TRAP_PC  (TRAP_PC)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_valid   (imem_valid),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .opcode       (opcode),
        .funct        (funct),
        .PC_s         (PC_s),
        .jr_target    (jr_target),
        .retire       (retire),
        .pc           (pc),
        .pc_plus4     (pc_plus4)
`ifdef FETCH_ALIGN_CHECK_EN
       ,.misalign_err (misalign_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Architectural next-PC rule, in plain arithmetic.
    function automatic logic [31:0] modelTarget(input logic [31:0] cur_pc, input logic [31:0] ir,
                                                input logic [1:0] sel, input logic [31:0] jr);
        logic [31:0] seq;
        longint      off;
        seq = cur_pc + 32'd4;
        case (sel)
            2'b01:   return jr;
            2'b10: begin
                off = longint'($signed(ir[15:0])) * 4;
                return seq + off[31:0];
            end
            2'b11:   return (seq & 32'hF000_0000) | ({6'b0, ir[25:0]} * 32'd4);
            default: return seq;
        endcase
    endfunction

    function automatic logic [31:0] modelLand(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
        return (t % 4 != 0) ? TRAP_PC : t;
`else
        return t - (t % 4);
`endif
    endfunction

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_have;
    logic        m_req;
    logic        m_err;

    // Model: a request is pending from the cycle after reset until a response is
    // taken; a held instruction leaves on retire and a new request starts.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc    <= RESET_PC;
            m_instr <= 32'h0;
            m_have  <= 1'b0;
            m_req   <= 1'b0;
            m_err   <= 1'b0;
        end else if (!m_have) begin
            if (m_req && imem_valid) begin
                m_instr <= imem_rdata;
                m_have  <= 1'b1;
                m_req   <= 1'b0;
            end else begin
                m_req   <= 1'b1;
            end
        end else if (retire) begin
            m_pc   <= modelLand(modelTarget(m_pc, m_instr, PC_s, jr_target));
            m_err  <= m_err | (modelTarget(m_pc, m_instr, PC_s, jr_target) % 4 != 0);
            m_have <= 1'b0;
            m_req  <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_req", imem_req, 1'b0);
            checkOutput("rst_valid", instr_valid, 1'b0);
            checkOutput("rst_pc", pc, RESET_PC);
        end else begin
            checkOutput("req", imem_req, m_req);
            if (m_req)
                checkOutput("addr", imem_addr, m_pc);
            checkOutput("instr_valid", instr_valid, m_have);
            checkOutput("pc", pc, m_pc);
            checkOutput("pc_plus4", pc_plus4, m_pc + 32'd4);
            if (m_have) begin
                checkOutput("instr", instr, m_instr);
                checkOutput("opcode", opcode, m_instr >> 26);
                checkOutput("funct", funct, m_instr % 64);
            end
`ifdef FETCH_ALIGN_CHECK_EN
            checkOutput("misalign_err", misalign_err, m_err);
`endif
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r,
                                 input logic [1:0] s, input logic [31:0] j);
        imem_valid = v;
        imem_rdata = d;
        retire     = r;
        PC_s       = s;
        jr_target  = j;
        @(posedge clk);
        #2;
    endtask

    task automatic waitReq();
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++)
            applyStimulus(1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
        checkOutput("req_timeout", imem_req, 1'b1);
    endtask

    task automatic doFetch(input logic [31:0] data, input int waits);
        waitReq();
        for (int i = 0; i < waits; i++)
            applyStimulus(1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
        applyStimulus(1'b1, data, 1'b0, 2'b00, 32'h0);
        imem_valid = 1'b0;
    endtask

    task automatic doRetire(input logic [1:0] sel, input logic [31:0] j);
        applyStimulus(1'b0, 32'h0, 1'b1, sel, j);
        retire = 1'b0;
        PC_s   = 2'b00;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Reset release with a 3-wait-cycle response.
        applyStimulus(1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
        checkOutput("lit_first_req", imem_req, 1'b1);
        checkOutput("lit_first_addr", imem_addr, 32'h0000_0000);
        doFetch(32'h2008_0005, 3);
        checkOutput("lit_first_valid", instr_valid, 1'b1);
        checkOutput("lit_first_opcode", opcode, 6'b001000);
        checkOutput("lit_first_funct", funct, 6'd5);

        // Sequential step from 0x100.
        doRetire(2'b01, 32'h0000_0100);
        checkOutput("lit_jr_100", pc, 32'h0000_0100);
        doFetch(32'h0000_0020, 0);
        doRetire(2'b00, 32'h0);
        checkOutput("lit_seq_pc", pc, 32'h0000_0104);
        checkOutput("lit_seq_req", imem_req, 1'b1);

        // Backward branch from 0x200.
        doFetch(32'h0000_0008, 0);
        doRetire(2'b01, 32'h0000_0200);
        doFetch(32'h1000_FFFE, 1);
        doRetire(2'b10, 32'h0);
        checkOutput("lit_branch_back", pc, 32'h0000_01FC);

        // Sequential wrap at the top of the address space.
        doFetch(32'h0000_0008, 0);
        doRetire(2'b01, 32'hFFFF_FFFC);
        doFetch(32'h0000_0020, 0);
        checkOutput("lit_plus4_wrap", pc_plus4, 32'h0000_0000);
        doRetire(2'b00, 32'h0);
        checkOutput("lit_seq_wrap", pc, 32'h0000_0000);

        // Pseudo-direct jump, then jr.
        doFetch(32'h0000_0008, 0);
        doRetire(2'b01, 32'h4000_0010);
        doFetch(32'h0800_0040, 2);
        doRetire(2'b11, 32'h0);
        checkOutput("lit_jump", pc, 32'h4000_0100);
        doFetch(32'h0000_0008, 0);
        doRetire(2'b01, 32'h0000_3000);
        checkOutput("lit_jr_3000", pc, 32'h0000_3000);

        // Stray response during EXEC is dropped.
        doFetch(32'hAAAA_0001, 0);
        applyStimulus(1'b1, 32'hBBBB_0002, 1'b0, 2'b00, 32'h0);
        imem_valid = 1'b0;
        checkOutput("lit_stray_valid", instr, 32'hAAAA_0001);

        // Stray retire during FETCH is ignored.
        doRetire(2'b00, 32'h0);
        checkOutput("lit_pc_3004", pc, 32'h0000_3004);
        doRetire(2'b01, 32'h0000_5000);
        checkOutput("lit_stray_retire_pc", pc, 32'h0000_3004);
        checkOutput("lit_stray_retire_req", imem_req, 1'b1);

        // Reset mid-fetch; a late response right after release is not taken.
        rst = 1'b1;
        #1;
        checkOutput("lit_midrst_req", imem_req, 1'b0);
        checkOutput("lit_midrst_pc", pc, RESET_PC);
        checkOutput("lit_midrst_instr", instr, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 2'b00, 32'h0);
        imem_valid = 1'b0;
        checkOutput("lit_late_valid", instr_valid, 1'b0);
        checkOutput("lit_late_req", imem_req, 1'b1);
        doFetch(32'h2008_0005, 0);
        checkOutput("lit_refetch", instr, 32'h2008_0005);

        // Misaligned jr target.
        doRetire(2'b01, 32'h0000_3002);
`ifdef FETCH_ALIGN_CHECK_EN
        checkOutput("lit_trap_pc", pc, TRAP_PC);
        checkOutput("lit_trap_err", misalign_err, 1'b1);
`else
        checkOutput("lit_align_pc", pc, 32'h0000_3000);
`endif
        doFetch(32'h0000_0020, 0);
        doRetire(2'b00, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        checkOutput("lit_trap_next", pc, TRAP_PC + 32'd4);
        checkOutput("lit_err_sticky", misalign_err, 1'b1);
`else
        checkOutput("lit_align_next", pc, 32'h0000_3004);
`endif
        applyStimulus(1'b0, 32'h0, 1'b0, 2'b00, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
